hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline control block for the 5-stage RV32I core. It consumes the hazard requests raised by the ID-stage load-use stall detector, the EX-stage branch/jump redirect and the MEM-stage data-memory handshake.
- It drives per-stage register enables and flushes (bubble insertion), and owns a watchdog on data-memory waits.
- Small FSM with Mealy outputs. Sits beside the pipeline registers in the core top level.

Parameters:
- TIMEOUT_CYCLES, 255: max consecutive MEM_WAIT cycles before bus error; legal range 1..2^WAIT_W-1.
- WAIT_W, 8: width of the wait counter.
- CNT_W, 32: width of the performance counters (optional feature).

Ports:
- CLK  input  1  core clock, rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- STALL  input  1  load-use stall request from the ID-stage detector.
- BRANCH_TAKEN  input  1  EX-stage redirect (taken branch, JAL, JALR).
- DMEM_REQ  input  1  MEM stage holds a valid load/store this cycle.
- DMEM_READY  input  1  data memory completes the access this cycle.
- PC_EN  output  1  PC register update enable.
- IF_ID_EN  output  1  IF/ID register enable.
- ID_EX_EN  output  1  ID/EX register enable.
- EX_MEM_EN  output  1  EX/MEM register enable.
- IF_ID_FLUSH  output  1  load NOP into IF/ID.
- ID_EX_FLUSH  output  1  load bubble (control zeroed) into ID/EX.
- MEM_WB_FLUSH  output  1  load bubble into MEM/WB.
- BUS_ERR  output  1  sticky data-memory timeout flag.
- LU_STALL_CNT, FLUSH_CNT, MEM_WAIT_CNT  output  CNT_W each  performance counters (optional feature).

Behaviour:
- States: INIT, RUN, LU_STALL, MEM_WAIT, ERROR. Async reset forces INIT, clears the wait counter and BUS_ERR.
- Outputs are combinational from state and inputs. State and counters are registered.

INIT:
- PC_EN=ID_EX_EN=IF_ID_EN=EX_MEM_EN=0; IF_ID_FLUSH=ID_EX_FLUSH=MEM_WB_FLUSH=1; BUS_ERR=0.
- These are the output values during and immediately after reset.
- Next state is always RUN (exactly one cycle).

RUN, evaluated in priority order each cycle:
1. DMEM_REQ & !DMEM_READY: all EN=0, MEM_WB_FLUSH=1, other flushes 0. Wait counter loads 1. Next state MEM_WAIT.
2. BRANCH_TAKEN: all EN=1, IF_ID_FLUSH=1, ID_EX_FLUSH=1. Any simultaneous STALL is discarded because the stalled instruction is being squashed. Stay in RUN.
3. STALL: PC_EN=0, IF_ID_EN=0, ID_EX_EN=1, ID_EX_FLUSH=1, EX_MEM_EN=1. Next state LU_STALL.
4. Otherwise: all EN=1, all flushes 0.

LU_STALL:
- STALL is ignored for exactly this cycle, since the bubble now in EX cannot trigger a second stall.
- Priorities 1, 2 and 4 of RUN apply.
- Next state is RUN, or MEM_WAIT if priority 1 fires.

MEM_WAIT:
- Pipeline frozen: all EN=0, MEM_WB_FLUSH=1. BRANCH_TAKEN and STALL are ignored; they are re-presented after release.
- DMEM_READY=1: outputs equal RUN priority 4 this cycle (the whole pipe advances), counter clears, next state RUN.
- Else counter increments. When the counter equals TIMEOUT_CYCLES without READY, next state is ERROR.
- DMEM_REQ dropping while waiting is treated as READY.

ERROR:
- All EN=0, all flushes 1, BUS_ERR=1.
- Exit only by reset.

General rules:
- The wait counter saturates and never wraps.
- Reset asserted mid-MEM_WAIT or mid-ERROR returns the block to INIT asynchronously.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - LU_STALL_CNT increments on each cycle RUN takes priority 3.
  - FLUSH_CNT increments on each cycle priority 2 applies.
  - MEM_WAIT_CNT increments on each cycle spent in MEM_WAIT without READY.
  - All counters wrap modulo 2^CNT_W, reset to 0, and hold in ERROR.
- Undefined: the counter registers are not built; the three ports are tied to 0.

Test Plan:
- Reset release → INIT outputs for 1 cycle (PC_EN=0, all flushes 1), then RUN with all EN=1 and flushes 0.
- STALL=1 held for 2 cycles in RUN → cycle 1: PC_EN=0, IF_ID_EN=0, ID_EX_FLUSH=1. Cycle 2 (LU_STALL): STALL ignored, PC_EN=1. LU_STALL_CNT=1 with macro.
- STALL=1 and BRANCH_TAKEN=1 in the same cycle → PC_EN=1, IF_ID_FLUSH=1, ID_EX_FLUSH=1, state stays RUN, LU_STALL_CNT unchanged.
- DMEM_REQ=1, DMEM_READY=0 for 3 cycles, then READY=1 → all EN=0 and MEM_WB_FLUSH=1 for 3 cycles, all EN=1 on the READY cycle. MEM_WAIT_CNT=2 with macro, because the first wait cycle is spent in RUN.
- TIMEOUT_CYCLES=4, DMEM_READY stuck at 0 → ERROR entered after the 4th MEM_WAIT cycle, BUS_ERR=1, all EN=0. A later READY=1 has no effect. RESET_N pulse low → INIT, BUS_ERR=0.
- BRANCH_TAKEN=1 during MEM_WAIT → no flush asserted, EN stay 0. Pipeline resumes normally on READY.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline control for the 5-stage RV32I core.
// Arbitrates the ID load-use stall, the EX redirect and the MEM data-memory
// handshake into per-stage register enables and bubble flushes. A watchdog
// on data-memory waits latches a sticky bus error after TIMEOUT_CYCLES.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is
// defined; otherwise the counter ports are tied to zero.
module hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int WAIT_W         = 8,
  parameter int CNT_W          = 32
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             STALL,
  input  logic             BRANCH_TAKEN,
  input  logic             DMEM_REQ,
  input  logic             DMEM_READY,
  output logic             PC_EN,
  output logic             IF_ID_EN,
  output logic             ID_EX_EN,
  output logic             EX_MEM_EN,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_FLUSH,
  output logic             MEM_WB_FLUSH,
  output logic             BUS_ERR,
  output logic [CNT_W-1:0] LU_STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT,
  output logic [CNT_W-1:0] MEM_WAIT_CNT
);

  typedef enum logic [2:0] {
    S_INIT,
    S_RUN,
    S_LU_STALL,
    S_MEM_WAIT,
    S_ERROR
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_MAX   = '1;

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              bus_err_q;

  // Hazard decode shared by the next-state, output and counter logic.
  logic in_issue;      // RUN or LU_STALL: the pipe is accepting work
  logic mem_block;     // MEM stage is waiting on data memory
  logic mem_release;   // wait ends: ready, or the request was withdrawn
  logic take_mem;      // priority 1: enter MEM_WAIT
  logic take_branch;   // priority 2: squash IF/ID and ID/EX
  logic take_stall;    // priority 3: load-use bubble (RUN only)
  logic wait_timeout;  // watchdog expiry while waiting

  assign in_issue     = (state == S_RUN) || (state == S_LU_STALL);
  assign mem_block    = DMEM_REQ & ~DMEM_READY;
  assign mem_release  = DMEM_READY | ~DMEM_REQ;
  assign take_mem     = in_issue & mem_block;
  assign take_branch  = in_issue & ~mem_block & BRANCH_TAKEN;
  // LU_STALL ignores STALL: the bubble now in EX cannot raise a second stall.
  assign take_stall   = (state == S_RUN) & ~mem_block & ~BRANCH_TAKEN & STALL;
  assign wait_timeout = (state == S_MEM_WAIT) & ~mem_release & (wait_cnt == WAIT_LIMIT);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= S_INIT;
    else          state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    state_next = state;
    unique case (state)
      S_INIT: state_next = S_RUN;
      S_RUN, S_LU_STALL: begin
        if (take_mem)        state_next = S_MEM_WAIT;
        else if (take_stall) state_next = S_LU_STALL;
        else                 state_next = S_RUN;
      end
      S_MEM_WAIT: begin
        if (mem_release)       state_next = S_RUN;
        else if (wait_timeout) state_next = S_ERROR;
        else                   state_next = S_MEM_WAIT;
      end
      S_ERROR: state_next = S_ERROR;
      default: state_next = S_INIT;
    endcase
  end

  // Mealy outputs: enables and flushes from state plus current requests.
  always_comb begin
    PC_EN        = 1'b0;
    IF_ID_EN     = 1'b0;
    ID_EX_EN     = 1'b0;
    EX_MEM_EN    = 1'b0;
    IF_ID_FLUSH  = 1'b0;
    ID_EX_FLUSH  = 1'b0;
    MEM_WB_FLUSH = 1'b0;
    unique case (state)
      S_INIT, S_ERROR: begin
        IF_ID_FLUSH  = 1'b1;
        ID_EX_FLUSH  = 1'b1;
        MEM_WB_FLUSH = 1'b1;
      end
      S_RUN, S_LU_STALL: begin
        if (take_mem) begin
          MEM_WB_FLUSH = 1'b1;
        end else if (take_branch) begin
          PC_EN       = 1'b1;
          IF_ID_EN    = 1'b1;
          ID_EX_EN    = 1'b1;
          EX_MEM_EN   = 1'b1;
          IF_ID_FLUSH = 1'b1;
          ID_EX_FLUSH = 1'b1;
        end else if (take_stall) begin
          ID_EX_EN    = 1'b1;
          EX_MEM_EN   = 1'b1;
          ID_EX_FLUSH = 1'b1;
        end else begin
          PC_EN     = 1'b1;
          IF_ID_EN  = 1'b1;
          ID_EX_EN  = 1'b1;
          EX_MEM_EN = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        // Frozen until release; redirects and stalls are re-presented later.
        if (mem_release) begin
          PC_EN     = 1'b1;
          IF_ID_EN  = 1'b1;
          ID_EX_EN  = 1'b1;
          EX_MEM_EN = 1'b1;
        end else begin
          MEM_WB_FLUSH = 1'b1;
        end
      end
      default: begin
        IF_ID_FLUSH  = 1'b1;
        ID_EX_FLUSH  = 1'b1;
        MEM_WB_FLUSH = 1'b1;
      end
    endcase
  end

  // Data-memory wait counter: loads 1 on the cycle the wait starts, counts
  // unanswered wait cycles, clears on release, and saturates rather than wraps.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wait_cnt <= '0;
    end else if (take_mem) begin
      wait_cnt <= WAIT_W'(1);
    end else if (state == S_MEM_WAIT) begin
      if (mem_release)            wait_cnt <= '0;
      else if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Sticky bus error: set on watchdog expiry, cleared only by reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)          bus_err_q <= 1'b0;
    else if (wait_timeout) bus_err_q <= 1'b1;
  end

  assign BUS_ERR = bus_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] lu_stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] mem_wait_cnt_q;

  // Performance counters; they wrap naturally and freeze in ERROR because
  // none of the qualifying events can occur there.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      lu_stall_cnt_q <= '0;
      flush_cnt_q    <= '0;
      mem_wait_cnt_q <= '0;
    end else begin
      if (take_stall)  lu_stall_cnt_q <= lu_stall_cnt_q + CNT_W'(1);
      if (take_branch) flush_cnt_q    <= flush_cnt_q + CNT_W'(1);
      if ((state == S_MEM_WAIT) && !mem_release)
        mem_wait_cnt_q <= mem_wait_cnt_q + CNT_W'(1);
    end
  end

  assign LU_STALL_CNT = lu_stall_cnt_q;
  assign FLUSH_CNT    = flush_cnt_q;
  assign MEM_WAIT_CNT = mem_wait_cnt_q;
`else
  assign LU_STALL_CNT = '0;
  assign FLUSH_CNT    = '0;
  assign MEM_WAIT_CNT = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (TIMEOUT_CYCLES=4). Inputs change just after
// the rising edge; combinational outputs are checked mid-cycle.
module tb_hazard_ctrl;
  localparam int CNT_W = 32;

  logic             CLK = 1'b0;
  logic             RESET_N = 1'b0;
  logic             STALL = 1'b0;
  logic             BRANCH_TAKEN = 1'b0;
  logic             DMEM_REQ = 1'b0;
  logic             DMEM_READY = 1'b0;
  logic             PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN;
  logic             IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH, BUS_ERR;
  logic [CNT_W-1:0] LU_STALL_CNT, FLUSH_CNT, MEM_WAIT_CNT;

  int total = 0;
  int bad   = 0;

  // Output vectors: {PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN,
  //                  IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH, BUS_ERR}
  localparam logic [7:0] V_INIT  = 8'b0000_111_0;
  localparam logic [7:0] V_RUN   = 8'b1111_000_0;
  localparam logic [7:0] V_MEM   = 8'b0000_001_0;
  localparam logic [7:0] V_BR    = 8'b1111_110_0;
  localparam logic [7:0] V_STALL = 8'b0011_010_0;
  localparam logic [7:0] V_ERR   = 8'b0000_111_1;

  // Input codes: {STALL, BRANCH_TAKEN, DMEM_REQ, DMEM_READY}
  localparam logic [3:0] I_IDLE = 4'b0000;
  localparam logic [3:0] I_RDY  = 4'b0001;
  localparam logic [3:0] I_REQ  = 4'b0010;
  localparam logic [3:0] I_REQR = 4'b0011;
  localparam logic [3:0] I_BR   = 4'b0100;
  localparam logic [3:0] I_REQB = 4'b0110;
  localparam logic [3:0] I_STL  = 4'b1000;
  localparam logic [3:0] I_STB  = 4'b1100;

  hazard_ctrl #(
    .TIMEOUT_CYCLES(4),
    .WAIT_W(8),
    .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .STALL(STALL),
    .BRANCH_TAKEN(BRANCH_TAKEN),
    .DMEM_REQ(DMEM_REQ),
    .DMEM_READY(DMEM_READY),
    .PC_EN(PC_EN),
    .IF_ID_EN(IF_ID_EN),
    .ID_EX_EN(ID_EX_EN),
    .EX_MEM_EN(EX_MEM_EN),
    .IF_ID_FLUSH(IF_ID_FLUSH),
    .ID_EX_FLUSH(ID_EX_FLUSH),
    .MEM_WB_FLUSH(MEM_WB_FLUSH),
    .BUS_ERR(BUS_ERR),
    .LU_STALL_CNT(LU_STALL_CNT),
    .FLUSH_CNT(FLUSH_CNT),
    .MEM_WAIT_CNT(MEM_WAIT_CNT)
  );

  always #5 CLK = ~CLK;

  // Counter expectation: real value with the feature built, zero otherwise.
  function automatic logic [CNT_W-1:0] exp_cnt(input int v);
`ifdef HAZARD_PERF_CNT_EN
    return CNT_W'(v);
`else
    return '0;
`endif
  endfunction

  task automatic check(input string tag, input logic [CNT_W-1:0] obs,
                       input logic [CNT_W-1:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic check_out(input string tag, input logic [7:0] exp);
    check(tag, CNT_W'({PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN,
                       IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH, BUS_ERR}),
          CNT_W'(exp));
  endtask

  task automatic check_cnts(input string tag, input int lu, input int fl, input int mw);
    check({tag, ".lu"}, LU_STALL_CNT, exp_cnt(lu));
    check({tag, ".fl"}, FLUSH_CNT,    exp_cnt(fl));
    check({tag, ".mw"}, MEM_WAIT_CNT, exp_cnt(mw));
  endtask

  // One cycle: apply inputs just after the edge, check mid-cycle, advance.
  task automatic step(input string tag, input logic [3:0] in, input logic [7:0] exp);
    {STALL, BRANCH_TAKEN, DMEM_REQ, DMEM_READY} = in;
    #2;
    check_out(tag, exp);
    @(posedge CLK);
    #1;
  endtask

  // Asynchronous reset pulse, then one INIT cycle; ends just after the edge
  // that moves the block into RUN.
  task automatic do_reset(input string tag);
    {STALL, BRANCH_TAKEN, DMEM_REQ, DMEM_READY} = I_IDLE;
    RESET_N = 1'b0;
    #2;
    check_out({tag, ".in_reset"}, V_INIT);
    check_cnts({tag, ".in_reset"}, 0, 0, 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    #1;
    check_out({tag, ".init"}, V_INIT);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #1;
    do_reset("por");
    step("run_idle", I_IDLE, V_RUN);

    // Load-use stall held two cycles; second cycle is in LU_STALL.
    step("stall_c1", I_STL, V_STALL);
    step("stall_c2", I_STL, V_RUN);
    step("stall_after", I_IDLE, V_RUN);
    check_cnts("stall", 1, 0, 0);

    // Branch beats stall; the block must still be in RUN afterwards.
    step("br_stall", I_STB, V_BR);
    step("br_stall_run", I_STL, V_STALL);
    step("br_stall_lu", I_IDLE, V_RUN);
    check_cnts("br_stall", 2, 1, 0);

    // Three unanswered cycles (first in RUN), then READY.
    step("mw_c1", I_REQ, V_MEM);
    step("mw_c2", I_REQ, V_MEM);
    step("mw_c3", I_REQ, V_MEM);
    step("mw_ready", I_REQR, V_RUN);
    check_cnts("mw", 2, 1, 2);

    // Branch presented during MEM_WAIT is ignored, honoured after release.
    step("mwb_c1", I_REQ, V_MEM);
    step("mwb_br", I_REQB, V_MEM);
    step("mwb_ready", I_REQR, V_RUN);
    step("mwb_repl", I_BR, V_BR);
    step("mwb_idle", I_IDLE, V_RUN);
    check_cnts("mwb", 2, 2, 3);

    // Request dropped while waiting acts as READY.
    step("drop_c1", I_REQ, V_MEM);
    step("drop_rel", I_IDLE, V_RUN);
    step("drop_run", I_STL, V_STALL);
    step("drop_lu", I_IDLE, V_RUN);

    // Memory wait raised from LU_STALL.
    step("lumem_stall", I_STL, V_STALL);
    step("lumem_req", I_REQ, V_MEM);
    step("lumem_wait", I_REQ, V_MEM);
    step("lumem_ready", I_REQR, V_RUN);

    // Branch in LU_STALL: flush, next state RUN.
    step("lubr_stall", I_STL, V_STALL);
    step("lubr_br", I_STB, V_BR);
    step("lubr_run", I_STL, V_STALL);
    step("lubr_lu", I_RDY, V_RUN);
    check_cnts("mid", 6, 3, 4);

    // Watchdog: RUN cycle plus four MEM_WAIT cycles, then ERROR.
    step("to_run", I_REQ, V_MEM);
    step("to_w1", I_REQ, V_MEM);
    step("to_w2", I_REQ, V_MEM);
    step("to_w3", I_REQ, V_MEM);
    step("to_w4", I_REQ, V_MEM);
    step("err_ready", I_REQR, V_ERR);
    step("err_hold", I_STB, V_ERR);
    check_cnts("err", 6, 3, 8);

    do_reset("err_rst");
    step("err_rst_run", I_IDLE, V_RUN);

    // Reset asserted in the middle of a memory wait.
    step("rstmw_c1", I_REQ, V_MEM);
    step("rstmw_c2", I_REQ, V_MEM);
    do_reset("mw_rst");
    step("mw_rst_run", I_IDLE, V_RUN);
    step("mw_rst_stall", I_STL, V_STALL);
    check_cnts("final", 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net in case the clock or sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end
endmodule
